fm_op_pipe: RTL and testbench

- Per-operator output pipeline for the FM audio engine: folds a 10-bit operator phase into a quarter-wave index, drives the log-sine ROM, adds scaled attenuation, drives the exp ROM, then shifts and signs the result.
- Sums a burst of operator outputs into one saturated sample per slot.
- Sits between the phase/envelope generators upstream and the sample mixer downstream.
- Both ROMs sit outside the block and each has 1-cycle registered read latency.

---
 rtl/fm_op_pipe.sv | 178 +++++++++++++++++
 tb/tb_fm_op_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fm_op_pipe.sv
// ---------------------------------------------------------------------------
// fm_op_pipe
//   Per-operator output pipeline of the FM engine. Each operator's 10-bit
//   phase is folded to a quarter-wave index for the external log-sine ROM.
//   Scaled attenuation is added in the log domain and the result is split
//   into an exp-ROM address and a right-shift count. The ROM mantissa is
//   then shifted and signed. Operators of one slot are summed into a
//   saturated sample.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid/in_phase/in_atten/in_first/in_last
//                         operator request, one per cycle, no backpressure
//   logsin_addr/logsin_data  log-sine ROM (1-cycle registered read)
//   exp_addr/exp_data        exp ROM (1-cycle registered read)
//   op_valid/op_out       per-operator signed result, 3 edges after sampling
//   out_valid/out_sample  one-cycle strobe with the saturated slot sum
//
// Timing (T0 = edge that samples in_valid)
//   T0: logsin_addr registered.  T1: log-sine ROM data appears, operator
//   side-band moves to the ROM-wait stage, exp_addr (combinational from the
//   log-sine data) becomes valid.  T2: exp ROM samples exp_addr, shift is
//   registered.  T3: op_out/op_valid.  T4: accumulator / out_sample.
// ---------------------------------------------------------------------------
module fm_op_pipe #(
  parameter int ATTEN_W     = 10,
  parameter int ATTEN_SHIFT = 2,
  parameter int ACC_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [9:0]         in_phase,
  input  logic [ATTEN_W-1:0] in_atten,
  input  logic               in_first,
  input  logic               in_last,
  output logic [7:0]         logsin_addr,
  input  logic [11:0]        logsin_data,
  output logic [7:0]         exp_addr,
  input  logic [11:0]        exp_data,
  output logic               op_valid,
  output logic [12:0]        op_out,
  output logic               out_valid,
  output logic [ACC_W-1:0]   out_sample
);

  localparam int SUM_W = 14;

  // Stage 1: ROM address plus operator side-band
  logic [7:0]         logsin_addr_q;
  logic               s1_sign_q, s1_first_q, s1_last_q, s1_valid_q;
  logic [ATTEN_W-1:0] s1_atten_q;

  // ROM-wait stage: side-band aligned with logsin_data
  logic               rw_sign_q, rw_first_q, rw_last_q, rw_valid_q;
  logic [ATTEN_W-1:0] rw_atten_q;
  logic               live_q;

  // Stage 2: shift count aligned with exp_data
  logic [4:0]         shift_q;
  logic               s2_sign_q, s2_first_q, s2_last_q, s2_valid_q;

  // Stage 3: operator result
  logic [12:0]        op_out_q;
  logic               op_valid_q, s3_first_q, s3_last_q;

  // Accumulator / sample output
  logic [ACC_W-1:0]   acc_q, out_sample_q;
  logic               out_valid_q;

  // Combinational next-state values
  logic [SUM_W-1:0]   sum_raw_d;
  logic [12:0]        sum_d;
  logic [11:0]        mag_d;
  logic [12:0]        op_out_d;
  logic [ACC_W-1:0]   acc_base_d;
  logic [ACC_W:0]     acc_wide_d;
  logic [ACC_W-1:0]   acc_d;

  always_comb begin
    sum_raw_d = SUM_W'(logsin_data) + (SUM_W'(rw_atten_q) << ATTEN_SHIFT);
    // Log-domain clamp: anything at or beyond 8191 is effectively silence.
    sum_d     = (sum_raw_d > SUM_W'(8191)) ? 13'h1FFF : sum_raw_d[12:0];

    // The ROM mantissa is 12 bits wide, so shifts of 12 or more leave nothing.
    mag_d     = (shift_q >= 5'd12) ? 12'd0 : (exp_data >> shift_q);
    op_out_d  = s2_sign_q ? -{1'b0, mag_d} : {1'b0, mag_d};

    acc_base_d = s3_first_q ? '0 : acc_q;
    acc_wide_d = {acc_base_d[ACC_W-1], acc_base_d}
               + {{(ACC_W-12){op_out_q[12]}}, op_out_q};
    // Overflow shows as disagreement between the guard bit and the sign bit.
    if (acc_wide_d[ACC_W] != acc_wide_d[ACC_W-1]) begin
      acc_d = acc_wide_d[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_d = acc_wide_d[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      logsin_addr_q <= '0;
      s1_sign_q     <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_atten_q    <= '0;
      rw_sign_q     <= 1'b0;
      rw_first_q    <= 1'b0;
      rw_last_q     <= 1'b0;
      rw_valid_q    <= 1'b0;
      rw_atten_q    <= '0;
      live_q        <= 1'b0;
      shift_q       <= '0;
      s2_sign_q     <= 1'b0;
      s2_first_q    <= 1'b0;
      s2_last_q     <= 1'b0;
      s2_valid_q    <= 1'b0;
      op_out_q      <= '0;
      op_valid_q    <= 1'b0;
      s3_first_q    <= 1'b0;
      s3_last_q     <= 1'b0;
      acc_q         <= '0;
      out_sample_q  <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      // Stage 1: second and fourth quarters read the table mirrored.
      logsin_addr_q <= in_phase[8] ? ~in_phase[7:0] : in_phase[7:0];
      s1_sign_q     <= in_phase[9];
      s1_atten_q    <= in_atten;
      s1_first_q    <= in_first;
      s1_last_q     <= in_last;
      s1_valid_q    <= in_valid;

      rw_sign_q     <= s1_sign_q;
      rw_atten_q    <= s1_atten_q;
      rw_first_q    <= s1_first_q;
      rw_last_q     <= s1_last_q;
      rw_valid_q    <= s1_valid_q;
      live_q        <= 1'b1;

      // Stage 2: the exp ROM samples exp_addr on this same edge.
      shift_q       <= sum_d[12:8];
      s2_sign_q     <= rw_sign_q;
      s2_first_q    <= rw_first_q;
      s2_last_q     <= rw_last_q;
      s2_valid_q    <= rw_valid_q;

      // Stage 3
      op_out_q      <= op_out_d;
      op_valid_q    <= s2_valid_q;
      s3_first_q    <= s2_first_q;
      s3_last_q     <= s2_last_q;

      // Accumulator
      out_valid_q   <= 1'b0;
      if (op_valid_q) begin
        if (s3_last_q) begin
          out_sample_q <= acc_d;
          out_valid_q  <= 1'b1;
          acc_q        <= '0;
        end else begin
          acc_q        <= acc_d;
        end
      end
    end
  end

  assign logsin_addr = logsin_addr_q;
  // Held at 0 until the first edge after reset so every output starts at 0.
  assign exp_addr    = live_q ? sum_d[7:0] : 8'd0;
  assign op_valid    = op_valid_q;
  assign op_out      = op_out_q;
  assign out_valid   = out_valid_q;
  assign out_sample  = out_sample_q;

endmodule

// File: tb/tb_fm_op_pipe.sv
// ---------------------------------------------------------------------------
// tb_fm_op_pipe
//   Directed bench for fm_op_pipe with small behavioural ROM models that
//   hold only the table entries the vectors reach.
// ---------------------------------------------------------------------------
module tb_fm_op_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  in_phase = '0;
  logic [9:0]  in_atten = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  logsin_addr;
  logic [11:0] logsin_data = '0;
  logic [7:0]  exp_addr;
  logic [11:0] exp_data = '0;
  logic        op_valid;
  logic [12:0] op_out;
  logic        out_valid;
  logic [15:0] out_sample;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int op_cnt = 0;
  int out_cnt = 0;
  int last_op_cyc = 0;
  logic signed [15:0] last_sample = '0;

  fm_op_pipe #(.ATTEN_W(10), .ATTEN_SHIFT(2), .ACC_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_phase(in_phase),
    .in_atten(in_atten), .in_first(in_first), .in_last(in_last),
    .logsin_addr(logsin_addr), .logsin_data(logsin_data),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .op_valid(op_valid), .op_out(op_out),
    .out_valid(out_valid), .out_sample(out_sample)
  );

  always #5 clk = ~clk;

  // Partial tables: -256*log2(sin((i+0.5)*pi/512)) and 2048*2^(-i/256).
  function automatic logic [11:0] logsin_f(input logic [7:0] a);
    case (a)
      8'd0:    return 12'd2137;
      8'd255:  return 12'd0;
      default: return 12'd1000;
    endcase
  endfunction

  function automatic logic [11:0] exp_f(input logic [7:0] a);
    case (a)
      8'd0:    return 12'd2048;
      8'd89:   return 12'd1609;
      8'd255:  return 12'd1027;
      default: return 12'd1500;
    endcase
  endfunction

  always @(posedge clk) begin
    logsin_data <= logsin_f(logsin_addr);
    exp_data    <= exp_f(exp_addr);
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (op_valid === 1'b1) begin
      op_cnt = op_cnt + 1;
      last_op_cyc = cyc;
    end
    if (out_valid === 1'b1) begin
      out_cnt = out_cnt + 1;
      last_sample = out_sample;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] ph, input logic [9:0] at,
                       input logic f, input logic l);
    in_valid = v;
    in_phase = ph;
    in_atten = at;
    in_first = f;
    in_last  = l;
  endtask

  // One single-operator slot, stage outputs checked edge by edge.
  task automatic run_single(input string tag, input logic [9:0] ph, input logic [9:0] at,
                            input int exp_la, input int exp_ea, input int exp_op);
    @(posedge clk); #1; drive(1'b1, ph, at, 1'b1, 1'b1);
    @(posedge clk); #1; drive(1'b0, '0, '0, 1'b0, 1'b0);          // T0
    @(negedge clk); chk({tag, "_laddr"}, 32'(logsin_addr), exp_la);
    @(posedge clk);                                                // T1
    @(negedge clk); chk({tag, "_eaddr"}, 32'(exp_addr), exp_ea);
    @(posedge clk);                                                // T2
    @(negedge clk); chk({tag, "_early"}, 32'(op_valid), 0);
    @(posedge clk);                                                // T3
    @(negedge clk);
    chk({tag, "_opv"}, 32'(op_valid), 1);
    chk({tag, "_op"}, 32'($signed(op_out)), exp_op);
    $display("op %s phase=%h atten=%0d op_out=%0d", tag, ph, at, $signed(op_out));
    @(posedge clk);                                                // T4
    @(negedge clk);
    chk({tag, "_outv"}, 32'(out_valid), 1);
    chk({tag, "_smp"}, 32'($signed(out_sample)), exp_op);
    @(posedge clk);
    @(negedge clk); chk({tag, "_outv0"}, 32'(out_valid), 0);
  endtask

  // n operators on consecutive cycles, first on #0 and last on #n-1.
  task automatic burst(input string tag, input logic [9:0] ph, input logic [9:0] at,
                       input int n, input int exp_smp);
    int base_op, base_out, c0;
    base_op  = op_cnt;
    base_out = out_cnt;
    c0 = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (i == 1) c0 = cyc;
      #1; drive(1'b1, ph, at, (i == 0), (i == n - 1));
    end
    @(posedge clk);
    if (n == 1) c0 = cyc;
    #1; drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (n + 8) @(posedge clk);
    @(negedge clk);
    chk({tag, "_opcnt"}, op_cnt - base_op, n);
    chk({tag, "_oplast"}, last_op_cyc, c0 + 1 + 3 + (n - 1));
    chk({tag, "_outcnt"}, out_cnt - base_out, 1);
    chk({tag, "_smp"}, 32'(last_sample), exp_smp);
    $display("burst %s phase=%h atten=%0d n=%0d sample=%0d", tag, ph, at, n, last_sample);
  endtask

  initial begin
    int base_op, base_out;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_laddr", 32'(logsin_addr), 0);
    chk("rst_eaddr", 32'(exp_addr), 0);
    chk("rst_opv",   32'(op_valid), 0);
    chk("rst_op",    32'(op_out), 0);
    chk("rst_outv",  32'(out_valid), 0);
    chk("rst_smp",   32'(out_sample), 0);
    reset_n = 1'b1;

    // sum 2137 = 0x859 -> addr 0x59, shift 8, 1609>>8 = 6
    run_single("ph000",   10'h000, 10'd0,    8'h00, 8'h59, 6);
    run_single("ph0ff",   10'h0FF, 10'd0,    8'hFF, 8'h00, 2048);
    run_single("ph100",   10'h100, 10'd0,    8'hFF, 8'h00, 2048);
    run_single("ph2ff",   10'h2FF, 10'd0,    8'hFF, 8'h00, -2048);
    run_single("ph200",   10'h200, 10'd0,    8'h00, 8'h59, -6);
    // atten 64 -> +256 -> addr 0, shift 1 -> 1024
    run_single("att64",   10'h0FF, 10'd64,   8'hFF, 8'h00, 1024);
    // 2137 + 4092 = 6229 = 0x1855 -> addr 0x55, shift 24 -> 0
    run_single("attmax0", 10'h000, 10'd1023, 8'h00, 8'h55, 0);
    // 0 + 4092 = 0xFFC -> addr 0xFC, shift 15 -> 0
    run_single("attmaxf", 10'h0FF, 10'd1023, 8'hFF, 8'hFC, 0);

    burst("sat_pos", 10'h0FF, 10'd0,  16, 32767);
    burst("sat_neg", 10'h2FF, 10'd0,  16, -32768);
    burst("sum3",    10'h0FF, 10'd64, 3,  3072);

    // Single-op slot followed by an operator without first: continues from 0.
    base_out = out_cnt;
    @(posedge clk); #1; drive(1'b1, 10'h0FF, 10'd0,  1'b1, 1'b1);
    @(posedge clk); #1; drive(1'b1, 10'h0FF, 10'd64, 1'b0, 1'b0);
    @(posedge clk); #1; drive(1'b1, 10'h0FF, 10'd64, 1'b0, 1'b1);
    @(posedge clk); #1; drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("nofirst_cnt", out_cnt - base_out, 2);
    chk("nofirst_smp", 32'(last_sample), 2048);
    $display("slot nofirst samples=%0d last=%0d", out_cnt - base_out, last_sample);

    // op_valid without last never produces a sample.
    base_op  = op_cnt;
    base_out = out_cnt;
    @(posedge clk); #1; drive(1'b1, 10'h0FF, 10'd0, 1'b1, 1'b0);
    @(posedge clk); #1; drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("nolast_op",  op_cnt - base_op, 1);
    chk("nolast_out", out_cnt - base_out, 0);
    $display("slot nolast ops=%0d samples=%0d", op_cnt - base_op, out_cnt - base_out);

    // Mid-slot reset: 4 of 8 operators issued, then reset drops everything.
    base_out = out_cnt;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; drive(1'b1, 10'h0FF, 10'd0, (i == 0), 1'b0);
    end
    @(posedge clk); #3;
    reset_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mrst_opv",   32'(op_valid), 0);
    chk("mrst_laddr", 32'(logsin_addr), 0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mrst_out", out_cnt - base_out, 0);
    $display("midreset samples=%0d", out_cnt - base_out);
    run_single("postrst", 10'h0FF, 10'd0, 8'hFF, 8'h00, 2048);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence needs only a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
